// File: rtl/bus_mem_responder_if.sv
// CPU-side strobe/address/status signals of the memory responder plus the back-door load port.
// r and w are level strobes. The master holds a strobe until it sees ready, then drops it for at least one edge.
// ready means read data is valid, or the write has been committed.
// bus_err is a one-cycle pulse that ends the access with no data.
interface bus_mem_responder_if #(
  parameter int DEPTH_LOG2 = 10
);
  logic [15:0]           adress_bus;
  logic                  r;
  logic                  w;
  logic                  ready;
  logic                  bus_err;
  logic                  ld_en;
  logic [DEPTH_LOG2-1:0] ld_addr;
  logic [7:0]            ld_data;
  logic [1:0]            o_dbg_state;
  logic                  o_dbg_drive;

  modport master (
    output adress_bus, r, w, ld_en, ld_addr, ld_data,
    input  ready, bus_err, o_dbg_state, o_dbg_drive
  );

  modport slave (
    input  adress_bus, r, w, ld_en, ld_addr, ld_data,
    output ready, bus_err, o_dbg_state, o_dbg_drive
  );
endinterface

// File: rtl/bus_mem_responder.sv
// Byte-wide memory target on the CPU bus: window decode, optional wait states,
// write-protected low region, back-door preload and a tri-state data bus.
module bus_mem_responder #(
  parameter logic [15:0] ADDR_BASE   = 16'h2000,
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_STATES = 0,
  parameter int          WP_BYTES    = 0
) (
  input  logic                clk,
  input  logic                reset,
  bus_mem_responder_if.slave  bus,
  inout  wire  [7:0]          date_bus
);
  localparam int          DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [16:0] WIN_SIZE = 17'(DEPTH);
  localparam logic [2:0]  WAIT_LOAD = 3'(WAIT_STATES);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WAIT       = 2'd1;
  localparam logic [1:0] S_READ_DRIVE = 2'd2;
  localparam logic [1:0] S_WRITE_DONE = 2'd3;

  logic [1:0]            r_state;
  logic [2:0]            r_cnt;
  logic                  r_bus_err;
  logic                  r_is_wr;
  logic [DEPTH_LOG2-1:0] r_off;
  logic [7:0]            r_wdata;
  logic [7:0]            r_mem [DEPTH];

  logic [15:0]           w_off;
  logic                  w_in_win;
  logic                  w_wp;
  logic                  w_drive;
  logic [7:0]            w_rdata;
  logic                  w_mem_we;
  logic [DEPTH_LOG2-1:0] w_mem_waddr;
  logic [7:0]            w_mem_wdata;

  // Addresses below the base wrap to a large offset and fall outside the window.
  assign w_off    = bus.adress_bus - ADDR_BASE;
  assign w_in_win = {1'b0, w_off} < WIN_SIZE;

  generate
    if (WP_BYTES > 0) begin : g_wp
      assign w_wp = {1'b0, w_off} < 17'(WP_BYTES);
    end else begin : g_no_wp
      assign w_wp = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      r_bus_err <= 1'b0;
      r_is_wr   <= 1'b0;
      r_off     <= '0;
      r_wdata   <= 8'd0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.r && bus.w) begin
            r_bus_err <= 1'b1;
          end else if (bus.r) begin
            if (!w_in_win) begin
              r_bus_err <= 1'b1;
            end else begin
              r_off   <= w_off[DEPTH_LOG2-1:0];
              r_is_wr <= 1'b0;
              r_cnt   <= WAIT_LOAD;
              r_state <= (WAIT_STATES > 0) ? S_WAIT : S_READ_DRIVE;
            end
          end else if (bus.w) begin
            if (!w_in_win || w_wp) begin
              r_bus_err <= 1'b1;
            end else begin
              r_off   <= w_off[DEPTH_LOG2-1:0];
              r_is_wr <= 1'b1;
              r_wdata <= date_bus;
              r_cnt   <= WAIT_LOAD;
              r_state <= (WAIT_STATES > 0) ? S_WAIT : S_WRITE_DONE;
            end
          end
        end
        S_WAIT: begin
          if (r_is_wr ? !bus.w : !bus.r) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
          end else if (r_cnt <= 3'd1) begin
            r_state <= r_is_wr ? S_WRITE_DONE : S_READ_DRIVE;
            r_cnt   <= 3'd0;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_READ_DRIVE: begin
          if (bus.w) begin
            r_bus_err <= 1'b1;
            r_state   <= S_IDLE;
          end else if (!bus.r) begin
            r_state <= S_IDLE;
          end
        end
        S_WRITE_DONE: begin
          if (!bus.w) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Single memory write port shared by zero-wait commits, delayed commits and back-door loads.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = '0;
    w_mem_wdata = 8'd0;
    if (reset) begin
      if (r_state == S_IDLE) begin
        if (bus.w && !bus.r && w_in_win && !w_wp && (WAIT_STATES == 0)) begin
          w_mem_we    = 1'b1;
          w_mem_waddr = w_off[DEPTH_LOG2-1:0];
          w_mem_wdata = date_bus;
        end else if (!bus.r && !bus.w && bus.ld_en) begin
          w_mem_we    = 1'b1;
          w_mem_waddr = bus.ld_addr;
          w_mem_wdata = bus.ld_data;
        end
      end else if (r_state == S_WAIT && r_is_wr && bus.w && r_cnt <= 3'd1) begin
        w_mem_we    = 1'b1;
        w_mem_waddr = r_off;
        w_mem_wdata = r_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
  end

  // The bus is released the moment w rises or reset asserts, without waiting for an edge.
  assign w_rdata  = r_mem[r_off];
  assign w_drive  = reset && (r_state == S_READ_DRIVE) && !bus.w;
  assign date_bus = w_drive ? w_rdata : 8'bz;

  assign bus.ready       = (r_state == S_READ_DRIVE) || (r_state == S_WRITE_DONE);
  assign bus.bus_err     = r_bus_err;
  assign bus.o_dbg_state = r_state;
  assign bus.o_dbg_drive = w_drive;
endmodule

// File: tb/tb_bus_mem_responder.sv
// Two responders (zero-wait with write protect, three-wait without) share one stimulus
// stream; a transaction-level model predicts each one's ready/bus_err/drive/data.
module tb_bus_mem_responder;
  localparam int NDUT = 2;
  localparam int WS0 = 0;
  localparam int WP0 = 16;
  localparam int WS1 = 3;
  localparam int WP1 = 0;
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] adr;
  logic        rs;
  logic        wstb;
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [7:0]  ld_data;
  logic        wdrv_en;
  logic [7:0]  wdata;
  wire  [7:0]  db0;
  wire  [7:0]  db1;

  bus_mem_responder_if #(.DEPTH_LOG2(10)) if0 ();
  bus_mem_responder_if #(.DEPTH_LOG2(10)) if1 ();

  assign if0.adress_bus = adr;
  assign if0.r          = rs;
  assign if0.w          = wstb;
  assign if0.ld_en      = ld_en;
  assign if0.ld_addr    = ld_addr;
  assign if0.ld_data    = ld_data;
  assign if1.adress_bus = adr;
  assign if1.r          = rs;
  assign if1.w          = wstb;
  assign if1.ld_en      = ld_en;
  assign if1.ld_addr    = ld_addr;
  assign if1.ld_data    = ld_data;
  assign db0 = wdrv_en ? wdata : 8'bz;
  assign db1 = wdrv_en ? wdata : 8'bz;

  bus_mem_responder #(.ADDR_BASE(16'h2000), .DEPTH_LOG2(10), .WAIT_STATES(WS0), .WP_BYTES(WP0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(if0), .date_bus(db0)
  );
  bus_mem_responder #(.ADDR_BASE(16'h2000), .DEPTH_LOG2(10), .WAIT_STATES(WS1), .WP_BYTES(WP1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1), .date_bus(db1)
  );

  int          ws_of [NDUT] = '{WS0, WS1};
  int          wp_of [NDUT] = '{WP0, WP1};
  logic [7:0]  exp_mem [NDUT][1024];
  logic [7:0]  exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic obs_rdy(int d);
    return (d == 0) ? if0.ready : if1.ready;
  endfunction
  function automatic logic obs_err(int d);
    return (d == 0) ? if0.bus_err : if1.bus_err;
  endfunction
  function automatic logic obs_drv(int d);
    return (d == 0) ? if0.o_dbg_drive : if1.o_dbg_drive;
  endfunction
  function automatic logic [1:0] obs_state(int d);
    return (d == 0) ? if0.o_dbg_state : if1.o_dbg_state;
  endfunction
  function automatic logic [7:0] obs_data(int d);
    return (d == 0) ? db0 : db1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_dut(input int d, input string tag, input logic e_rdy, input logic e_err,
                           input logic e_drv, input logic [7:0] e_data);
    check($sformatf("%s%0d.rdy", tag, d), 32'(obs_rdy(d)), 32'(e_rdy));
    check($sformatf("%s%0d.err", tag, d), 32'(obs_err(d)), 32'(e_err));
    check($sformatf("%s%0d.drv", tag, d), 32'(obs_drv(d)), 32'(e_drv));
    if (e_drv) check($sformatf("%s%0d.data", tag, d), 32'(obs_data(d)), 32'(e_data));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edge k = 0 is the edge that samples the strobe; a legal access shows ready from edge k = WAIT_STATES on.
  task automatic do_read(input logic [15:0] addr, input int hold);
    logic [15:0] o;
    logic        win;
    logic [7:0]  exp_rd [NDUT];
    o   = addr - 16'h2000;
    win = (o < 16'd1024);
    for (int d = 0; d < NDUT; d++) exp_q.push_back(exp_mem[d][o[9:0]]);
    for (int d = 0; d < NDUT; d++) exp_rd[d] = exp_q.pop_front();
    adr = addr;
    rs  = 1'b1;
    for (int k = 0; k < hold; k++) begin
      tick();
      for (int d = 0; d < NDUT; d++)
        check_dut(d, "rd", win && (k >= ws_of[d]), !win, win && (k >= ws_of[d]), exp_rd[d]);
    end
    rs = 1'b0;
    tick();
    for (int d = 0; d < NDUT; d++) check_dut(d, "rd_end", 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] data, input int hold);
    logic [15:0] o;
    logic        legal [NDUT];
    o = addr - 16'h2000;
    for (int d = 0; d < NDUT; d++) legal[d] = (o < 16'd1024) && (int'(o) >= wp_of[d]);
    adr     = addr;
    wstb    = 1'b1;
    wdrv_en = 1'b1;
    wdata   = data;
    for (int k = 0; k < hold; k++) begin
      tick();
      for (int d = 0; d < NDUT; d++)
        check_dut(d, "wr", legal[d] && (k >= ws_of[d]), !legal[d], 1'b0, 8'd0);
    end
    for (int d = 0; d < NDUT; d++)
      if (legal[d] && hold > ws_of[d]) exp_mem[d][o[9:0]] = data;
    wstb    = 1'b0;
    wdrv_en = 1'b0;
    tick();
    for (int d = 0; d < NDUT; d++) check_dut(d, "wr_end", 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic do_load(input logic [9:0] off, input logic [7:0] data);
    ld_en   = 1'b1;
    ld_addr = off;
    ld_data = data;
    tick();
    ld_en = 1'b0;
    for (int d = 0; d < NDUT; d++) exp_mem[d][off] = data;
  endtask

  initial begin
    logic [7:0]  wr_byte;
    logic [15:0] ra;
    int          sel;
    int          hold;
    adr = 16'd0; rs = 1'b0; wstb = 1'b0; ld_en = 1'b0;
    ld_addr = 10'd0; ld_data = 8'd0; wdrv_en = 1'b0; wdata = 8'd0;

    #2;
    for (int d = 0; d < NDUT; d++) begin
      check_dut(d, "rst", 1'b0, 1'b0, 1'b0, 8'd0);
      check($sformatf("rst%0d.state", d), 32'(obs_state(d)), 32'(ST_IDLE));
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    for (int i = 0; i < 1024; i++) do_load(10'(i), 8'($urandom_range(0, 255)));
    do_load(10'd0, 8'hA5);
    do_load(10'd1, 8'h3C);
    do_read(16'h2000, 5);
    do_read(16'h2001, 5);

    do_write(16'h2010, 8'h77, 5);
    do_read(16'h2010, 5);
    do_read(16'h1FFF, 1);
    do_read(16'h2400, 2);

    do_write(16'h2005, 8'h55, 5);
    do_read(16'h2005, 5);
    do_load(10'd5, 8'h55);
    do_read(16'h2005, 5);

    // r and w together
    adr = 16'h2030; rs = 1'b1; wstb = 1'b1; wdrv_en = 1'b1; wdata = ~exp_mem[0][10'h30];
    tick();
    for (int d = 0; d < NDUT; d++) check_dut(d, "rw", 1'b0, 1'b1, 1'b0, 8'd0);
    rs = 1'b0; wstb = 1'b0; wdrv_en = 1'b0;
    tick();
    for (int d = 0; d < NDUT; d++) check_dut(d, "rw_end", 1'b0, 1'b0, 1'b0, 8'd0);
    do_read(16'h2030, 5);

    // w rising while the read data is on the bus
    adr = 16'h2001; rs = 1'b1;
    repeat (4) tick();
    for (int d = 0; d < NDUT; d++) check_dut(d, "cont_pre", 1'b1, 1'b0, 1'b1, exp_mem[d][10'd1]);
    wstb = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) check($sformatf("cont%0d.release", d), 32'(obs_drv(d)), 32'd0);
    tick();
    for (int d = 0; d < NDUT; d++) begin
      check_dut(d, "cont_err", 1'b0, 1'b1, 1'b0, 8'd0);
      check($sformatf("cont%0d.state", d), 32'(obs_state(d)), 32'(ST_IDLE));
    end
    rs = 1'b0; wstb = 1'b0;
    tick();
    for (int d = 0; d < NDUT; d++) check_dut(d, "cont_end", 1'b0, 1'b0, 1'b0, 8'd0);

    // reset while driving read data
    adr = 16'h2000; rs = 1'b1;
    repeat (4) tick();
    #2 reset = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check_dut(d, "rst_rd", 1'b0, 1'b0, 1'b0, 8'd0);
      check($sformatf("rst_rd%0d.state", d), 32'(obs_state(d)), 32'(ST_IDLE));
    end
    rs = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();

    // reset in the wait phase of a write: only the zero-wait responder has committed
    wr_byte = ~exp_mem[1][10'h20];
    adr = 16'h2020; wstb = 1'b1; wdrv_en = 1'b1; wdata = wr_byte;
    repeat (2) tick();
    #2 reset = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check_dut(d, "rst_wr", 1'b0, 1'b0, 1'b0, 8'd0);
      check($sformatf("rst_wr%0d.state", d), 32'(obs_state(d)), 32'(ST_IDLE));
    end
    exp_mem[0][10'h20] = wr_byte;
    wstb = 1'b0; wdrv_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    do_read(16'h2020, 5);
    do_read(16'h2000, 5);

    for (int i = 0; i < 60; i++) begin
      sel  = int'($urandom_range(0, 9));
      hold = int'($urandom_range(1, 6));
      if ($urandom_range(0, 7) == 0) ra = 16'($urandom);
      else ra = 16'h2000 + 16'($urandom_range(0, 1023));
      if (sel < 5) do_read(ra, hold);
      else if (sel < 9) do_write(ra, 8'($urandom), hold);
      else do_load(10'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
